// File: rtl/delay_wakeup_array.sv
// -----------------------------------------------------------------------------
// delay_wakeup_array
//
// Holds up to ENTRIES in-flight wakeups. Each accepted issue broadcasts its
// tag on the single wake port a programmable number of cycles later. A
// reservation vector marks future cycles that already own the wake port, so
// at most one wakeup fires per cycle and none is ever dropped or merged.
//
// Ports
//   clk         : single clock, all state on the rising edge
//   rst         : asynchronous active-low reset
//   issu_en     : issue request this cycle
//   issu_tag    : tag to broadcast at wakeup
//   issu_lat    : wakeup latency in cycles (valid range 1..MAXLAT)
//   flush       : synchronous kill of every pending wakeup
//   issu_ready  : comb, at least one free entry
//   issu_ack    : comb, request accepted this cycle
//   issu_err    : comb, request rejected for an illegal latency
//   wake_valid  : registered one-cycle wakeup strobe
//   wake_tag    : registered tag, meaningful while wake_valid is high
//   occupancy   : registered count of busy entries
// -----------------------------------------------------------------------------
module delay_wakeup_array #(
  parameter int  ENTRIES = 4,
  parameter int  MAXLAT  = 8,
  parameter int  TAG_W   = 6,
  localparam int LAT_W   = $clog2(MAXLAT + 1),
  localparam int OCC_W   = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issu_en,
  input  logic [TAG_W-1:0] issu_tag,
  input  logic [LAT_W-1:0] issu_lat,
  input  logic             flush,
  output logic             issu_ready,
  output logic             issu_ack,
  output logic             issu_err,
  output logic             wake_valid,
  output logic [TAG_W-1:0] wake_tag,
  output logic [OCC_W-1:0] occupancy
);

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [LAT_W-1:0]   cnt_q [ENTRIES];
  logic [LAT_W-1:0]   cnt_d [ENTRIES];
  // res_q[j] set: some wakeup fires at the (j-1)-th edge after the next one,
  // i.e. res_q[1] means the upcoming edge already owns the wake port.
  logic [MAXLAT:1]    res_q, res_d;
  logic               wake_valid_q, wake_valid_d;
  logic [TAG_W-1:0]   wake_tag_q, wake_tag_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic               lat_ok;
  logic               res_hit;
  logic               alloc_done;

  // Request qualification uses current-cycle state only; an entry freed at
  // the coming edge is not visible here until the following cycle.
  always_comb begin
    lat_ok  = (issu_lat != '0) && (issu_lat <= LAT_W'(MAXLAT));
    res_hit = 1'b0;
    for (int j = 1; j <= MAXLAT; j++) begin
      if (res_q[j] && (issu_lat == LAT_W'(j))) res_hit = 1'b1;
    end
  end

  assign issu_ready = ~&busy_q;
  assign issu_ack   = issu_en & ~flush & issu_ready & lat_ok & ~res_hit;
  assign issu_err   = issu_en & ~flush & ~lat_ok;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    busy_d       = busy_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    res_d        = res_q >> 1;  // one edge closer for every reservation
    wake_valid_d = 1'b0;
    wake_tag_d   = wake_tag_q;
    alloc_done   = 1'b0;
    occ_d        = '0;

    // Expiry: an entry with one cycle left fires and frees at this edge.
    // The reservation check guarantees at most one such entry.
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i]) begin
        if (cnt_q[i] == LAT_W'(1)) begin
          busy_d[i]    = 1'b0;
          wake_valid_d = 1'b1;
          wake_tag_d   = tag_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] - LAT_W'(1);
        end
      end
    end

    if (issu_ack) begin
      if (issu_lat == LAT_W'(1)) begin
        // Latency 1 fires at the accepting edge; no entry is ever held.
        wake_valid_d = 1'b1;
        wake_tag_d   = issu_tag;
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (!alloc_done && !busy_q[i]) begin
            busy_d[i]  = 1'b1;
            tag_d[i]   = issu_tag;
            cnt_d[i]   = issu_lat - LAT_W'(1);
            alloc_done = 1'b1;
          end
        end
        // Reservation placed in post-shift coordinates: fire edge is
        // issu_lat-1 edges after the next one.
        for (int j = 1; j < MAXLAT; j++) begin
          if (issu_lat == LAT_W'(j + 1)) res_d[j] = 1'b1;
        end
      end
    end

    if (flush) begin
      busy_d       = '0;
      res_d        = '0;
      wake_valid_d = 1'b0;
    end

    for (int i = 0; i < ENTRIES; i++) begin
      occ_d = occ_d + OCC_W'(busy_d[i]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      // NOTE: the small tag/counter arrays are reset too, so no X ever
      // reaches wake_tag or the expiry compare after reset.
      tag_q        <= '{default: '0};
      cnt_q        <= '{default: '0};
      res_q        <= '0;
      wake_valid_q <= 1'b0;
      wake_tag_q   <= '0;
      occ_q        <= '0;
    end else begin
      busy_q       <= busy_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      wake_valid_q <= wake_valid_d;
      wake_tag_q   <= wake_tag_d;
      occ_q        <= occ_d;
    end
  end

  assign wake_valid = wake_valid_q;
  assign wake_tag   = wake_tag_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_delay_wakeup_array.sv
// -----------------------------------------------------------------------------
// tb_delay_wakeup_array
//
// Self-checking bench. The reference model is a list of pending wakeups, each
// holding the absolute edge number at which it fires and its tag. Directed
// scenarios pin the model with literal expectations; a randomized run then
// compares the DUT with the model every cycle.
// -----------------------------------------------------------------------------
module tb_delay_wakeup_array;

  localparam int ENTRIES = 4;
  localparam int MAXLAT  = 8;
  localparam int TAG_W   = 6;
  localparam int LAT_W   = $clog2(MAXLAT + 1);
  localparam int OCC_W   = $clog2(ENTRIES + 1);

  logic             clk;
  logic             rst;
  logic             issu_en;
  logic [TAG_W-1:0] issu_tag;
  logic [LAT_W-1:0] issu_lat;
  logic             flush;
  logic             issu_ready;
  logic             issu_ack;
  logic             issu_err;
  logic             wake_valid;
  logic [TAG_W-1:0] wake_tag;
  logic [OCC_W-1:0] occupancy;

  delay_wakeup_array #(
    .ENTRIES (ENTRIES),
    .MAXLAT  (MAXLAT),
    .TAG_W   (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issu_en    (issu_en),
    .issu_tag   (issu_tag),
    .issu_lat   (issu_lat),
    .flush      (flush),
    .issu_ready (issu_ready),
    .issu_ack   (issu_ack),
    .issu_err   (issu_err),
    .wake_valid (wake_valid),
    .wake_tag   (wake_tag),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               fire;
    logic [TAG_W-1:0] tag;
  } wk_t;

  wk_t              pend[$];
  int               edge_n;
  logic             m_wv;
  logic [TAG_W-1:0] m_wt;

  int n_cmp;
  int n_bad;

  logic last_ready, last_ack, last_err;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)",
               name, act, exp, edge_n, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare combinational outputs, let
  // the edge happen, advance the model, compare registered outputs.
  task automatic step(input bit en, input logic [TAG_W-1:0] tg,
                      input logic [LAT_W-1:0] lt, input bit fl);
    bit m_ready, m_ack, m_err, ok, conflict;
    @(negedge clk);
    issu_en  = en;
    issu_tag = tg;
    issu_lat = lt;
    flush    = fl;
    #1;
    ok       = (lt >= 1) && (int'(lt) <= MAXLAT);
    m_ready  = pend.size() < ENTRIES;
    conflict = 1'b0;
    foreach (pend[i]) if (pend[i].fire == edge_n + int'(lt) - 1) conflict = 1'b1;
    m_err = en && !fl && !ok;
    m_ack = en && !fl && m_ready && ok && !conflict;
    last_ready = issu_ready;
    last_ack   = issu_ack;
    last_err   = issu_err;
    check("issu_ready", issu_ready, m_ready);
    check("issu_ack",   issu_ack,   m_ack);
    check("issu_err",   issu_err,   m_err);

    @(posedge clk);
    m_wv = 1'b0;
    if (fl) begin
      pend.delete();
    end else begin
      if (m_ack) pend.push_back('{fire: edge_n + int'(lt) - 1, tag: tg});
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].fire == edge_n) begin
          m_wv = 1'b1;
          m_wt = pend[i].tag;
          pend.delete(i);
        end
      end
    end
    edge_n++;
    #1;
    check("wake_valid", wake_valid, m_wv);
    if (m_wv) check("wake_tag", wake_tag, m_wt);
    check("occupancy", occupancy, pend.size());
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset pulse placed strictly between two rising edges.
  task automatic reset_pulse();
    @(negedge clk);
    issu_en = 1'b0;
    flush   = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_wake_valid", wake_valid, 0);
    check("rst_wake_tag",   wake_tag,   0);
    check("rst_occupancy",  occupancy,  0);
    check("rst_ready",      issu_ready, 1);
    pend.delete();
    m_wv = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    edge_n   = 0;
    m_wv     = 1'b0;
    m_wt     = '0;
    rst      = 1'b0;
    issu_en  = 1'b0;
    issu_tag = '0;
    issu_lat = '0;
    flush    = 1'b0;
    #1;
    check("init_wake_valid", wake_valid, 0);
    check("init_occupancy",  occupancy,  0);
    check("init_ready",      issu_ready, 1);
    #1;
    rst = 1'b1;

    // Single issue, latency 3.
    step(1'b1, 6'h15, 4'd3, 1'b0);
    check("d1_ack", last_ack, 1);
    check("d1_occ_after_issue", occupancy, 1);
    idle(1);
    check("d1_no_early_wake", wake_valid, 0);
    idle(1);
    check("d1_wake", wake_valid, 1);
    check("d1_tag", wake_tag, 6'h15);
    check("d1_occ_after_wake", occupancy, 0);
    idle(1);
    check("d1_strobe_one_cycle", wake_valid, 0);

    // Slot conflict: lat 4 then lat 3 collides.
    step(1'b1, 6'h0a, 4'd4, 1'b0);
    step(1'b1, 6'h0b, 4'd3, 1'b0);
    check("d2_conflict_ack", last_ack, 0);
    check("d2_conflict_err", last_err, 0);
    idle(4);
    // lat 4 then lat 2 wakes one cycle earlier.
    step(1'b1, 6'h0a, 4'd4, 1'b0);
    step(1'b1, 6'h0c, 4'd2, 1'b0);
    check("d2_ack_lat2", last_ack, 1);
    idle(1);
    check("d2_first_wake_tag", wake_tag, 6'h0c);
    idle(1);
    check("d2_second_wake_tag", wake_tag, 6'h0a);
    idle(2);

    // Fill all entries, fifth issue must stall.
    for (int k = 0; k < 4; k++) step(1'b1, 6'(6'h20 + k), 4'd8, 1'b0);
    check("d3_occ_full", occupancy, 4);
    step(1'b1, 6'h2f, 4'd8, 1'b0);
    check("d3_ready_full", last_ready, 0);
    check("d3_ack_full", last_ack, 0);
    for (int e = 5; e <= 10; e++) begin
      idle(1);
      if (e >= 7) check("d3_wake_order", wake_tag, 6'(6'h20 + e - 7));
    end
    idle(1);

    // Illegal latencies.
    step(1'b1, 6'h01, 4'd0, 1'b0);
    check("d4_err_lat0", last_err, 1);
    check("d4_ack_lat0", last_ack, 0);
    step(1'b1, 6'h02, 4'd9, 1'b0);
    check("d4_err_lat9", last_err, 1);
    check("d4_occ", occupancy, 0);

    // Flush at the edge of the first expiry.
    step(1'b1, 6'h31, 4'd4, 1'b0);
    step(1'b1, 6'h32, 4'd4, 1'b0);
    step(1'b1, 6'h33, 4'd4, 1'b0);
    step(1'b1, 6'h34, 4'd2, 1'b1);
    check("d5_flush_wake", wake_valid, 0);
    check("d5_flush_occ", occupancy, 0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("d5_no_wake_after_flush", wake_valid, 0);
    end
    check("d5_ready", last_ready, 1);

    // Asynchronous reset with two pending.
    step(1'b1, 6'h3a, 4'd5, 1'b0);
    step(1'b1, 6'h3b, 4'd6, 1'b0);
    reset_pulse();
    for (int k = 0; k < 7; k++) begin
      idle(1);
      check("d6_no_wake_after_rst", wake_valid, 0);
    end

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      bit               en, fl;
      logic [TAG_W-1:0] tg;
      logic [LAT_W-1:0] lt;
      if ((n % 600) == 599) reset_pulse();
      en = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 39) == 0);
      tg = TAG_W'($urandom);
      if ($urandom_range(0, 9) == 0) lt = LAT_W'($urandom_range(0, 15));
      else                           lt = LAT_W'($urandom_range(1, MAXLAT));
      step(en, tg, lt, fl);
    end
    idle(MAXLAT + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/delay_wakeup_array.md
DELAY_WAKEUP_ARRAY -- requirements
Module: delay_wakeup_array

Interface
REQ-001 Parameter ENTRIES, default 4: number of in-flight wakeup entries (2..16).
REQ-002 Parameter MAXLAT, default 8: maximum wakeup latency in cycles (2..32).
REQ-003 Parameter TAG_W, default 6: width of the destination tag.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 issu_en  input  1  issue request this cycle.
REQ-007 issu_tag  input  TAG_W  tag to broadcast at wakeup.
REQ-008 issu_lat  input  clog2(MAXLAT+1)  wakeup latency in cycles.
REQ-009 flush  input  1  synchronous kill of all pending wakeups.
REQ-010 issu_ready  output  1  combinational: at least one free entry.
REQ-011 issu_ack  output  1  combinational: request accepted this cycle.
REQ-012 issu_err  output  1  combinational: request rejected, latency 0 or >MAXLAT.
REQ-013 wake_valid  output  1  registered one-cycle wakeup strobe.
REQ-014 wake_tag  output  TAG_W  registered tag, meaningful only while wake_valid=1.
REQ-015 occupancy  output  clog2(ENTRIES+1)  registered count of busy entries.

Function
REQ-016 Each entry SHALL hold busy bit, tag and down-counter; a reservation vector res[1..MAXLAT] SHALL mark future cycles already owning the wake port.
REQ-017 issu_ack SHALL equal issu_en & !flush & issu_ready & (1<=issu_lat<=MAXLAT) & !res[issu_lat].
REQ-018 issu_err SHALL equal issu_en & !flush & (issu_lat==0 | issu_lat>MAXLAT); no state change on error.
REQ-019 issu_ready and issu_ack SHALL be computed from current-cycle state only; an entry freed at an edge is not usable until the following cycle.
REQ-020 On acceptance at edge k, the lowest-index free entry SHALL be allocated; wake_valid=1 with wake_tag=issu_tag SHALL be visible in the cycle after edge k+L-1 (L=1: cycle immediately after edge k).
REQ-021 wake_valid SHALL be high for exactly one cycle per accepted request and 0 otherwise.
REQ-022 The reservation check SHALL guarantee at most one entry expires per cycle; no wakeup is ever dropped or merged.
REQ-023 A request with res[issu_lat]=1 SHALL be silently refused (issu_ack=0, issu_err=0); requester retries.
REQ-024 The entry SHALL be freed at the same edge that raises wake_valid; occupancy decrements there.
REQ-025 Allocation and expiry at the same edge SHALL net occupancy unchanged.
REQ-026 res SHALL shift toward index 1 every edge; the accepted latency bit SHALL be set after the shift.
REQ-027 flush=1 at edge k SHALL clear all busy bits, res and occupancy, and force wake_valid=0 after edge k, including a wakeup that would have fired then; issue in a flush cycle is ignored.
REQ-028 occupancy SHALL never exceed ENTRIES; when ENTRIES entries busy, issu_ready=0 and issu_ack=0.

Reset
REQ-029 rst=0 SHALL immediately clear all busy bits, res, counters, occupancy, wake_valid and wake_tag to 0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard all pending wakeups; none fire after release.
REQ-031 After rst deasserts, issu_ready=1 and the first issue may be accepted in the first clock cycle.

Verification
REQ-032 Single issue tag=0x15, lat=3 at edge 0 -> issu_ack=1; wake_valid=1, wake_tag=0x15 only in cycle after edge 2; occupancy 1 then 0.
REQ-033 Issue lat=4 at edge 0, then lat=3 at edge 1 -> second issu_ack=0 (slot conflict); lat=2 at edge 1 -> accepted, wakes one cycle before first.
REQ-034 Four issues lat=8 consecutive, fifth at edge 4 -> issu_ready=0, issu_ack=0, occupancy=4; wakes after edges 7,8,9,10 in issue order.
REQ-035 issu_lat=0 and issu_lat=9 (MAXLAT=8) -> issu_err=1, issu_ack=0, occupancy unchanged.
REQ-036 Three pending wakeups, flush at edge coinciding with first expiry -> no wake_valid thereafter, occupancy=0, issu_ready=1.
REQ-037 rst pulsed low between edges with two pending -> outputs 0 immediately, no wake_valid after release.
